// File: rtl/bus_arbiter_2m_if.sv
// Signal bundle for bus_arbiter_2m: two requesting masters, the shared slave bus and the grant vector.
// Modport master is the arbiter's view; modport slave is the view of the surrounding masters and slave.
interface bus_arbiter_2m_if;
  logic        m0_ss;
  logic        m0_ttype;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_done;
  logic        m0_err;

  logic        m1_ss;
  logic        m1_ttype;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_done;
  logic        m1_err;

  logic        s_ss;
  logic        s_ttype;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_bdone;

  logic [1:0]  gnt;

  modport master (
    input  m0_ss, m0_ttype, m0_addr, m0_wdata,
    output m0_rdata, m0_done, m0_err,
    input  m1_ss, m1_ttype, m1_addr, m1_wdata,
    output m1_rdata, m1_done, m1_err,
    output s_ss, s_ttype, s_addr, s_wdata,
    input  s_rdata, s_bdone,
    output gnt
  );

  modport slave (
    output m0_ss, m0_ttype, m0_addr, m0_wdata,
    input  m0_rdata, m0_done, m0_err,
    output m1_ss, m1_ttype, m1_addr, m1_wdata,
    input  m1_rdata, m1_done, m1_err,
    input  s_ss, s_ttype, s_addr, s_wdata,
    output s_rdata, s_bdone,
    input  gnt
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master arbiter (m1 has priority) sharing one slave bus; grant is held until the slave signals bdone.
// Optional macro BUS_TIMEOUT_EN: force an error completion after TIMEOUT_CYCLES grant cycles without bdone.
module bus_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input logic              clk,
  input logic              rst_n,
  bus_arbiter_2m_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_reg, state_next;
  logic   timeout;
  logic   xfer_end;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter_2m: TIMEOUT_CYCLES must be >= 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

`ifdef BUS_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Counter restarts for every new grant and saturates at CNT_MAX.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE || xfer_end) cnt_next = '0;
    else if (cnt_reg != CNT_MAX)       cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign timeout = (state_reg != IDLE) && !bus.s_bdone && (cnt_reg == CNT_MAX);
`else
  assign timeout = 1'b0;
`endif

  assign xfer_end = bus.s_bdone || timeout;

  always_comb begin
    state_next   = state_reg;
    bus.s_ss     = 1'b0;
    bus.s_ttype  = 1'b0;
    bus.s_addr   = '0;
    bus.s_wdata  = '0;
    bus.gnt      = 2'b00;
    bus.m0_rdata = '0;
    bus.m0_done  = 1'b0;
    bus.m0_err   = 1'b0;
    bus.m1_rdata = '0;
    bus.m1_done  = 1'b0;
    bus.m1_err   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.m1_ss)      state_next = GNT1;
        else if (bus.m0_ss) state_next = GNT0;
      end

      GNT0: begin
        bus.s_ss    = !timeout;
        bus.s_ttype = bus.m0_ttype;
        bus.s_addr  = bus.m0_addr;
        bus.s_wdata = bus.m0_wdata;
        bus.gnt     = 2'b01;
        // The finished master's ss is still high here, so hand over or idle, never regrant.
        if (xfer_end) begin
          bus.m0_done  = 1'b1;
          bus.m0_err   = timeout;
          bus.m0_rdata = timeout ? ERR_RDATA : bus.s_rdata;
          state_next   = bus.m1_ss ? GNT1 : IDLE;
        end
      end

      GNT1: begin
        bus.s_ss    = !timeout;
        bus.s_ttype = bus.m1_ttype;
        bus.s_addr  = bus.m1_addr;
        bus.s_wdata = bus.m1_wdata;
        bus.gnt     = 2'b10;
        if (xfer_end) begin
          bus.m1_done  = 1'b1;
          bus.m1_err   = timeout;
          bus.m1_rdata = timeout ? ERR_RDATA : bus.s_rdata;
          state_next   = bus.m0_ss ? GNT0 : IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed scenarios, then random traffic against a transaction-level model.
// Builds with or without BUS_TIMEOUT_EN; the DUT is instantiated with TIMEOUT_CYCLES=4.
module tb_bus_arbiter_2m;
  localparam int          TMO      = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arbiter_2m_if bus ();

  bus_arbiter_2m #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR_DATA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s cycle=%0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Reference model: who owns the bus (-1 none) and how long the owner has waited.
  int          owner, waited, owner_next, waited_next;
  logic        m_ss[2], m_tt[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [1:0]  e_gnt;
  logic        e_s_ss, e_s_ttype;
  logic [31:0] e_s_addr, e_s_wdata;
  logic        e_done[2], e_err[2];
  logic [31:0] e_rdata[2];

  task automatic model_eval();
    logic tmo, fin;
    m_ss[0] = bus.m0_ss;  m_tt[0] = bus.m0_ttype;  m_addr[0] = bus.m0_addr;  m_wdata[0] = bus.m0_wdata;
    m_ss[1] = bus.m1_ss;  m_tt[1] = bus.m1_ttype;  m_addr[1] = bus.m1_addr;  m_wdata[1] = bus.m1_wdata;
    e_gnt = 2'b00; e_s_ss = 1'b0; e_s_ttype = 1'b0; e_s_addr = '0; e_s_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = '0;
    end
    owner_next  = owner;
    waited_next = waited;
    if (!rst_n) begin
      owner_next = -1; waited_next = 0;
    end else if (owner < 0) begin
      if (m_ss[1])      owner_next = 1;
      else if (m_ss[0]) owner_next = 0;
      waited_next = 0;
    end else begin
      tmo = TMO_ON && !bus.s_bdone && (waited == TMO);
      fin = bus.s_bdone || tmo;
      e_gnt     = (owner == 0) ? 2'b01 : 2'b10;
      e_s_ss    = !tmo;
      e_s_ttype = m_tt[owner];
      e_s_addr  = m_addr[owner];
      e_s_wdata = m_wdata[owner];
      if (fin) begin
        e_done[owner]  = 1'b1;
        e_err[owner]   = tmo;
        e_rdata[owner] = tmo ? ERR_DATA : bus.s_rdata;
        owner_next     = m_ss[1 - owner] ? 1 - owner : -1;
        waited_next    = 0;
      end else begin
        waited_next = (waited < TMO) ? waited + 1 : TMO;
      end
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
    check_val("gnt",      32'(bus.gnt),      32'(e_gnt));
    check_val("s_ss",     32'(bus.s_ss),     32'(e_s_ss));
    check_val("s_ttype",  32'(bus.s_ttype),  32'(e_s_ttype));
    check_val("s_addr",   bus.s_addr,        e_s_addr);
    check_val("s_wdata",  bus.s_wdata,       e_s_wdata);
    check_val("m0_done",  32'(bus.m0_done),  32'(e_done[0]));
    check_val("m0_err",   32'(bus.m0_err),   32'(e_err[0]));
    check_val("m0_rdata", bus.m0_rdata,      e_rdata[0]);
    check_val("m1_done",  32'(bus.m1_done),  32'(e_done[1]));
    check_val("m1_err",   32'(bus.m1_err),   32'(e_err[1]));
    check_val("m1_rdata", bus.m1_rdata,      e_rdata[1]);
    for (int i = 0; i < 2; i++)
      if (e_done[i])
        $display("txn cyc=%0d m%0d %s addr=%h wdata=%h rdata=%h err=%0d", cyc, i,
                 m_tt[i] ? "WR" : "RD", m_addr[i], m_wdata[i], e_rdata[i], e_err[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin owner = -1; waited = 0; end
    else begin owner = owner_next; waited = waited_next; end
    cyc++;
    #1;
  endtask

  task automatic set_master(input int i, input logic ss, input logic tt, input logic [31:0] a,
                            input logic [31:0] w);
    if (i == 0) begin
      bus.m0_ss = ss; bus.m0_ttype = tt; bus.m0_addr = a; bus.m0_wdata = w;
    end else begin
      bus.m1_ss = ss; bus.m1_ttype = tt; bus.m1_addr = a; bus.m1_wdata = w;
    end
  endtask

  // Master contract: request fields frozen from assertion until done.
  logic [65:0] held[2];
  logic        held_act[2];
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_act[0] = 1'b0; held_act[1] = 1'b0;
    end else begin
      if (held_act[0])
        assert ({bus.m0_ss, bus.m0_ttype, bus.m0_addr, bus.m0_wdata} == held[0])
          else $error("m0 request changed before done");
      if (held_act[1])
        assert ({bus.m1_ss, bus.m1_ttype, bus.m1_addr, bus.m1_wdata} == held[1])
          else $error("m1 request changed before done");
      held_act[0] = bus.m0_ss && !bus.m0_done;
      held_act[1] = bus.m1_ss && !bus.m1_done;
      held[0] = {bus.m0_ss, bus.m0_ttype, bus.m0_addr, bus.m0_wdata};
      held[1] = {bus.m1_ss, bus.m1_ttype, bus.m1_addr, bus.m1_wdata};
    end
  end

  int   d0, d1, bad, gcnt;
  logic cur;
  logic last_done[2];

  initial begin
    owner = -1; waited = 0;
    rst_n = 1'b0;
    set_master(0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0);
    bus.s_rdata = '0; bus.s_bdone = 1'b0;
    last_done[0] = 1'b0; last_done[1] = 1'b0;
    #3;
    check_val("rst_gnt",      32'(bus.gnt),     32'h0);
    check_val("rst_s_ss",     32'(bus.s_ss),    32'h0);
    check_val("rst_m0_done",  32'(bus.m0_done), 32'h0);
    check_val("rst_m1_done",  32'(bus.m1_done), 32'h0);
    check_val("rst_s_addr",   bus.s_addr,       32'h0);
    check_val("rst_m1_rdata", bus.m1_rdata,     32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read, single-cycle slave
    set_master(0, 1, 0, 32'h0200_BFF8, 32'h0);
    bus.s_rdata = 32'h0000_0042; bus.s_bdone = 1'b1;
    settle(); check_val("t1_c0_gnt", 32'(bus.gnt), 32'h0); tick();
    settle();
    check_val("t1_gnt",    32'(bus.gnt),     32'h1);
    check_val("t1_s_addr", bus.s_addr,       32'h0200_BFF8);
    check_val("t1_done",   32'(bus.m0_done), 32'h1);
    check_val("t1_rdata",  bus.m0_rdata,     32'h42);
    tick();
    set_master(0, 0, 0, 0, 0);
    settle(); check_val("t1_c2_gnt", 32'(bus.gnt), 32'h0); tick();

    // Simultaneous request: m1 wins
    set_master(0, 1, 0, 32'h8000_0010, 32'h0);
    set_master(1, 1, 1, 32'h8000_0020, 32'h0000_1000);
    bus.s_rdata = 32'h0000_00AB;
    settle(); tick();
    settle();
    check_val("t2_gnt",     32'(bus.gnt),     32'h2);
    check_val("t2_s_wdata", bus.s_wdata,      32'h1000);
    check_val("t2_m1_done", 32'(bus.m1_done), 32'h1);
    check_val("t2_m0_idle", 32'(bus.m0_done), 32'h0);
    tick();
    set_master(1, 0, 0, 0, 0);
    settle();
    check_val("t2_gnt0",     32'(bus.gnt),     32'h1);
    check_val("t2_m0_done",  32'(bus.m0_done), 32'h1);
    check_val("t2_m0_rdata", bus.m0_rdata,     32'hAB);
    tick();
    set_master(0, 0, 0, 0, 0);
    settle(); check_val("t2_idle", 32'(bus.gnt), 32'h0); tick();

    // Sustained contention: ping-pong
    set_master(0, 1, 0, 32'h0000_0100, 32'h0);
    set_master(1, 1, 1, 32'h0000_0200, 32'h5A5A_0000);
    d0 = 0; d1 = 0; bad = 0;
    settle(); tick();
    for (int k = 1; k <= 8; k++) begin
      bus.s_rdata = $urandom;
      settle();
      if (bus.m0_done) d0++;
      if (bus.m1_done) d1++;
      if (bus.gnt != (((k % 2) != 0) ? 2'b10 : 2'b01)) bad++;
      tick();
    end
    check_val("t3_m0_dones", d0,  32'd4);
    check_val("t3_m1_dones", d1,  32'd4);
    check_val("t3_alt_bad",  bad, 32'd0);
    set_master(0, 0, 0, 0, 0);
    settle(); tick();
    set_master(1, 0, 0, 0, 0);
    settle(); tick();

    // Multi-cycle slave: 3 wait cycles
    set_master(0, 1, 0, 32'h1000_0004, 32'h0);
    bus.s_rdata = 32'h1234_5678; bus.s_bdone = 1'b0;
    settle(); tick();
    gcnt = 0; d0 = 0; bad = 0;
    for (int k = 0; k < 4; k++) begin
      bus.s_bdone = (k == 3);
      settle();
      if (bus.gnt == 2'b01) gcnt++;
      if (bus.m0_done) d0++;
      if (!bus.m0_done && bus.m0_rdata != 32'h0) bad++;
      if (bus.m0_done && bus.m0_rdata != 32'h1234_5678) bad++;
      tick();
    end
    check_val("t4_gnt_cycles", gcnt, 32'd4);
    check_val("t4_dones",      d0,   32'd1);
    check_val("t4_rdata_bad",  bad,  32'd0);
    set_master(0, 0, 0, 0, 0); bus.s_bdone = 1'b0;
    settle(); tick();

    // Reset during GNT1 with slave stalled
    set_master(1, 1, 1, 32'h0200_4000, 32'hCAFE_0001);
    settle(); tick();
    settle(); check_val("t5_pre_gnt", 32'(bus.gnt), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_gnt",     32'(bus.gnt),     32'h0);
    check_val("t5_s_ss",    32'(bus.s_ss),    32'h0);
    check_val("t5_m1_done", 32'(bus.m1_done), 32'h0);
    check_val("t5_s_addr",  bus.s_addr,       32'h0);
    tick();
    set_master(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    set_master(0, 1, 0, 32'h0000_0040, 32'h0);
    bus.s_bdone = 1'b1;
    settle(); tick();
    settle();
    check_val("t5_regnt", 32'(bus.gnt),     32'h1);
    check_val("t5_done",  32'(bus.m0_done), 32'h1);
    tick();
    set_master(0, 0, 0, 0, 0); bus.s_bdone = 1'b0;
    settle(); tick();

    // Slave that never answers
    set_master(1, 1, 0, 32'h0300_0000, 32'h0);
    bus.s_rdata = 32'h5555_5555;
    settle(); tick();
`ifdef BUS_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      settle();
      check_val("t6_wait_s_ss", 32'(bus.s_ss),    32'h1);
      check_val("t6_wait_done", 32'(bus.m1_done), 32'h0);
      tick();
    end
    settle();
    check_val("t6_tmo_s_ss", 32'(bus.s_ss),    32'h0);
    check_val("t6_tmo_done", 32'(bus.m1_done), 32'h1);
    check_val("t6_tmo_err",  32'(bus.m1_err),  32'h1);
    check_val("t6_tmo_data", bus.m1_rdata,     32'hDEAD_BEEF);
    tick();
`else
    for (int k = 0; k < 6; k++) begin
      settle();
      check_val("t6_hold_gnt",  32'(bus.gnt),     32'h2);
      check_val("t6_hold_done", 32'(bus.m1_done), 32'h0);
      tick();
    end
    bus.s_bdone = 1'b1;
    settle();
    check_val("t6_late_done", 32'(bus.m1_done), 32'h1);
    check_val("t6_late_err",  32'(bus.m1_err),  32'h0);
    tick();
    bus.s_bdone = 1'b0;
`endif
    set_master(1, 0, 0, 0, 0);
    settle(); tick();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        cur = (i == 0) ? bus.m0_ss : bus.m1_ss;
        if (!cur || last_done[i]) begin
          if ($urandom_range(0, 99) < (cur ? 50 : 35))
            set_master(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
          else
            set_master(i, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
      bus.s_bdone = ($urandom_range(0, 99) < 55);
      bus.s_rdata = $urandom;
      settle();
      last_done[0] = e_done[0];
      last_done[1] = e_done[1];
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
